// File: rtl/lpc_periph.sv
// LPC I/O target front end. It decodes host cycles on LAD and issues single-byte read/write
// requests to a local backend. It answers with SYNC, read data and turn-around nibbles.
module lpc_periph #(
    parameter logic [15:0] ADDR_BASE  = 16'h0000,
    parameter logic [15:0] ADDR_MASK  = 16'hFFF0,
    parameter int          WAIT_LIMIT = 8
) (
    input  logic        LPC_LCLK,
    input  logic        LPC_LRESET,
    input  logic        LPC_LFRAME,
    inout  wire  [3:0]  LPC_LAD,
    output logic [15:0] lpc_addr_o,
    output logic [7:0]  lpc_data_o,
    output logic        lpc_wr_o,
    output logic        lpc_rd_o,
    input  logic [7:0]  lpc_data_i,
    input  logic        lpc_ready_i,
    output logic [4:0]  lpc_periph_state_o
);

    localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(WAIT_LIMIT);

    localparam logic [3:0] SYNC_OK   = 4'b0000;
    localparam logic [3:0] SYNC_WAIT = 4'b0110;
    localparam logic [3:0] SYNC_ERR  = 4'b1010;

    typedef enum logic [4:0] {
        IDLE, START, CYCTYPE, ADDR1, ADDR2, ADDR3, ADDR4, DATA_WR1, DATA_WR2,
        TAR1, TAR2, SYNC, DATA_RD1, DATA_RD2, FTAR1, FTAR2
    } state_t;

    state_t        state_q;
    logic [15:0]   addr_q;
    logic [7:0]    wdata_q;
    logic [7:0]    rdata_q;
    logic          wr_q;
    logic          rd_q;
    logic          oe_q;
    logic [3:0]    lad_q;
    logic          is_wr_q;
    logic          ready_q;
    logic [CW-1:0] wait_q;

    logic [3:0]    lad_in;
    logic [15:0]   addr_d;
    logic [7:0]    rdata_d;
    logic          hit_d;
    logic          ready_d;
    logic          abort_d;

    function automatic logic addr_hit(input logic [15:0] a);
        return (a & ADDR_MASK) == (ADDR_BASE & ADDR_MASK);
    endfunction

    // An abort (LFRAME low) must free the bus in the same cycle, not one edge later.
    assign LPC_LAD = (oe_q && LPC_LFRAME) ? lad_q : 4'bzzzz;
    assign lad_in  = LPC_LAD;

    always_comb begin
        addr_d  = {addr_q[11:0], lad_in};
        hit_d   = is_wr_q ? addr_hit(addr_q) : addr_hit(addr_d);
        ready_d = ready_q | lpc_ready_i;
        rdata_d = (lpc_ready_i && !ready_q && !is_wr_q) ? lpc_data_i : rdata_q;
        abort_d = !LPC_LFRAME && (state_q != IDLE) && (state_q != START);
    end

    // The CYCTYPE encoding is reserved: the type nibble is decoded in the
    // START cycle that first sees LFRAME high.
    always_ff @(posedge LPC_LCLK or negedge LPC_LRESET) begin
        if (!LPC_LRESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            oe_q    <= 1'b0;
            lad_q   <= 4'b0000;
            is_wr_q <= 1'b0;
            ready_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            if (abort_d) begin
                oe_q    <= 1'b0;
                ready_q <= 1'b0;
                state_q <= (lad_in == 4'b0000) ? START : IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        oe_q    <= 1'b0;
                        ready_q <= 1'b0;
                        if (!LPC_LFRAME && lad_in == 4'b0000) state_q <= START;
                    end
                    START: begin
                        if (!LPC_LFRAME) begin
                            if (lad_in != 4'b0000) state_q <= IDLE;
                        end else if (lad_in == 4'b0000 || lad_in == 4'b0010) begin
                            is_wr_q <= lad_in[1];
                            state_q <= ADDR1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    ADDR1: begin addr_q <= addr_d; state_q <= ADDR2; end
                    ADDR2: begin addr_q <= addr_d; state_q <= ADDR3; end
                    ADDR3: begin addr_q <= addr_d; state_q <= ADDR4; end
                    ADDR4: begin
                        addr_q <= addr_d;
                        if (is_wr_q) begin
                            state_q <= DATA_WR1;
                        end else begin
                            rd_q    <= hit_d;
                            state_q <= TAR1;
                        end
                    end
                    DATA_WR1: begin wdata_q[3:0] <= lad_in; state_q <= DATA_WR2; end
                    DATA_WR2: begin
                        wdata_q[7:4] <= lad_in;
                        wr_q         <= hit_d;
                        state_q      <= TAR1;
                    end
                    TAR1: begin
                        if (!addr_hit(addr_q)) begin
                            state_q <= IDLE;
                        end else begin
                            ready_q <= ready_d;
                            rdata_q <= rdata_d;
                            state_q <= TAR2;
                        end
                    end
                    TAR2: begin
                        ready_q <= ready_d;
                        rdata_q <= rdata_d;
                        oe_q    <= 1'b1;
                        lad_q   <= ready_d ? SYNC_OK : SYNC_WAIT;
                        wait_q  <= ready_d ? '0 : CW'(1);
                        state_q <= SYNC;
                    end
                    SYNC: begin
                        if (lad_q == SYNC_OK) begin
                            ready_q <= 1'b0;
                            lad_q   <= is_wr_q ? 4'b1111 : rdata_q[3:0];
                            state_q <= is_wr_q ? FTAR1 : DATA_RD1;
                        end else if (lad_q == SYNC_ERR) begin
                            ready_q <= 1'b0;
                            lad_q   <= 4'b1111;
                            state_q <= FTAR1;
                        end else begin
                            ready_q <= ready_d;
                            rdata_q <= rdata_d;
                            if (ready_d) begin
                                lad_q <= SYNC_OK;
                            end else if (wait_q >= WAIT_MAX) begin
                                lad_q <= SYNC_ERR;
                            end else begin
                                lad_q  <= SYNC_WAIT;
                                wait_q <= wait_q + CW'(1);
                            end
                        end
                    end
                    DATA_RD1: begin lad_q <= rdata_q[7:4]; state_q <= DATA_RD2; end
                    DATA_RD2: begin lad_q <= 4'b1111; state_q <= FTAR1; end
                    FTAR1: begin
                        oe_q    <= 1'b0;
                        lad_q   <= 4'b0000;
                        state_q <= FTAR2;
                    end
                    FTAR2:   state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign lpc_addr_o         = addr_q;
    assign lpc_data_o         = wdata_q;
    assign lpc_wr_o           = wr_q;
    assign lpc_rd_o           = rd_q;
    assign lpc_periph_state_o = state_q;

endmodule
